// File: rtl/ins_fetch_q.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : ins_fetch_q
// Brief    : PC/fetch unit with static next-PC rules and an FQ_DEPTH-entry
//            decoupling queue feeding the decoder. Define IF_RVC_EN for RVC.
// Revision : 1.0
// ----------------------------------------------------------------------------
module ins_fetch_q #(
    parameter int                 DAT_W    = 32,
    parameter int                 FQ_DEPTH = 4,
    parameter int                 FQ_AW    = 2,
    parameter logic [DAT_W-1:0]   RST_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ic_en_i,
    input  logic [DAT_W-1:0]      ic_ins_i,
    output logic                  ic_en_o,
    output logic [DAT_W-1:0]      ic_pc_o,
    input  logic                  br_flag_i,
    input  logic                  br_abr_i,
    input  logic [DAT_W-1:0]      br_tpc_i,
    input  logic [DAT_W-1:0]      br_cbt_i,
    output logic [DAT_W-1:0]      bp_pc_o,
    input  logic                  bp_br_i,
    output logic                  bp_en_o,
    output logic                  bp_abr_o,
    output logic [DAT_W-1:0]      bp_tpc_o,
    output logic                  is_en_o,
    output logic                  is_ic_o,
    output logic [DAT_W-1:0]      is_ins_o,
    output logic [DAT_W-1:0]      is_pc_o,
    output logic                  is_pbr_o,
    input  logic                  full_i,
    output logic [FQ_AW:0]        fq_cnt_o
);

    localparam logic [FQ_AW:0]   c_depth = (FQ_AW+1)'(FQ_DEPTH);
    localparam logic [DAT_W-1:0] c_four  = DAT_W'(4);

    logic [DAT_W-1:0] r_pc;
    logic [FQ_AW-1:0] r_head;
    logic [FQ_AW-1:0] r_tail;
    logic [FQ_AW:0]   r_cnt;
    logic             r_ic_en;
    logic             r_is_en;
    logic             r_is_ic;
    logic             r_is_pbr;
    logic [DAT_W-1:0] r_is_ins;
    logic [DAT_W-1:0] r_is_pc;

    logic [DAT_W-1:0] r_q_pc  [FQ_DEPTH];
    logic [DAT_W-1:0] r_q_ins [FQ_DEPTH];
    logic             r_q_ic  [FQ_DEPTH];
    logic             r_q_pbr [FQ_DEPTH];

    logic             w_enq;
    logic             w_deq;
    logic             w_is_c;
    logic [DAT_W-1:0] w_imm_j;
    logic [DAT_W-1:0] w_imm_b;
    logic [DAT_W-1:0] w_npc;

    // Both decisions use the start-of-cycle count: no same-cycle bypass.
    assign w_enq = ic_en_i && (r_cnt < c_depth);
    assign w_deq = (r_cnt != '0) && !full_i;

    assign w_imm_j = {{(DAT_W-21){ic_ins_i[31]}}, ic_ins_i[31], ic_ins_i[19:12],
                      ic_ins_i[20], ic_ins_i[30:21], 1'b0};
    assign w_imm_b = {{(DAT_W-13){ic_ins_i[31]}}, ic_ins_i[31], ic_ins_i[7],
                      ic_ins_i[30:25], ic_ins_i[11:8], 1'b0};

`ifdef IF_RVC_EN
    localparam logic [DAT_W-1:0] c_two = DAT_W'(2);
    logic [DAT_W-1:0] w_imm_cj;
    logic [DAT_W-1:0] w_imm_cb;
    logic [4:0]       w_cop;

    assign w_is_c   = (ic_ins_i[1:0] != 2'b11);
    assign w_cop    = {ic_ins_i[15:13], ic_ins_i[1:0]};
    assign w_imm_cj = {{(DAT_W-12){ic_ins_i[12]}}, ic_ins_i[12], ic_ins_i[8],
                       ic_ins_i[10:9], ic_ins_i[6], ic_ins_i[7], ic_ins_i[2],
                       ic_ins_i[11], ic_ins_i[5:3], 1'b0};
    assign w_imm_cb = {{(DAT_W-9){ic_ins_i[12]}}, ic_ins_i[12], ic_ins_i[6:5],
                       ic_ins_i[2], ic_ins_i[11:10], ic_ins_i[4:3], 1'b0};
`else
    assign w_is_c   = 1'b0;
`endif

    always_comb begin
        w_npc = r_pc + c_four;
`ifdef IF_RVC_EN
        if (w_is_c) begin
            w_npc = r_pc + c_two;
            if (w_cop == 5'b00101 || w_cop == 5'b10101)
                w_npc = r_pc + w_imm_cj;
            else if ((w_cop == 5'b11001 || w_cop == 5'b11101) && bp_br_i)
                w_npc = r_pc + w_imm_cb;
        end else
`endif
        if (ic_ins_i[6:0] == 7'b1101111)
            w_npc = r_pc + w_imm_j;
        else if (ic_ins_i[6:0] == 7'b1100011 && bp_br_i)
            w_npc = r_pc + w_imm_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RST_PC;
            r_head   <= '0;
            r_tail   <= '0;
            r_cnt    <= '0;
            r_ic_en  <= 1'b0;
            r_is_en  <= 1'b0;
            r_is_ic  <= 1'b0;
            r_is_pbr <= 1'b0;
            r_is_ins <= '0;
            r_is_pc  <= '0;
        end else if (!en) begin
            r_ic_en  <= 1'b0;
            r_is_en  <= 1'b0;
        end else if (br_flag_i) begin
            r_pc     <= br_cbt_i;
            r_head   <= '0;
            r_tail   <= '0;
            r_cnt    <= '0;
            r_ic_en  <= 1'b0;
            r_is_en  <= 1'b0;
        end else begin
            r_ic_en <= !ic_en_i && (r_cnt < c_depth);
            if (w_enq) begin
                r_pc   <= w_npc;
                r_tail <= r_tail + 1'b1;
            end
            r_is_en <= w_deq;
            if (w_deq) begin
                r_is_pc  <= r_q_pc[r_head];
                r_is_ins <= r_q_ins[r_head];
                r_is_ic  <= r_q_ic[r_head];
                r_is_pbr <= r_q_pbr[r_head];
                r_head   <= r_head + 1'b1;
            end
            if (w_enq && !w_deq)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_enq && w_deq)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    // Payload storage needs no reset; validity is tracked by r_cnt.
    always_ff @(posedge clk) begin
        if (!rst && en && !br_flag_i && w_enq) begin
            r_q_pc[r_tail]  <= r_pc;
            r_q_ins[r_tail] <= ic_ins_i;
            r_q_ic[r_tail]  <= w_is_c;
            r_q_pbr[r_tail] <= bp_br_i;
        end
    end

    assign ic_en_o  = r_ic_en;
    assign ic_pc_o  = r_pc;
    assign bp_pc_o  = r_pc;
    assign bp_en_o  = br_flag_i;
    assign bp_abr_o = br_abr_i;
    assign bp_tpc_o = br_tpc_i;
    assign is_en_o  = r_is_en;
    assign is_ic_o  = r_is_ic;
    assign is_ins_o = r_is_ins;
    assign is_pc_o  = r_is_pc;
    assign is_pbr_o = r_is_pbr;
    assign fq_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch_q.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_ins_fetch_q
// Brief    : Directed self-checking bench for ins_fetch_q (honours IF_RVC_EN).
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_ins_fetch_q;

    logic        clk = 1'b0;
    logic        rst, en, ic_en_i, br_flag_i, br_abr_i, bp_br_i, full_i;
    logic [31:0] ic_ins_i, br_tpc_i, br_cbt_i;
    logic        ic_en_o, bp_en_o, bp_abr_o, is_en_o, is_ic_o, is_pbr_o;
    logic [31:0] ic_pc_o, bp_pc_o, bp_tpc_o, is_ins_o, is_pc_o;
    logic [2:0]  fq_cnt_o;

    int checks   = 0;
    int failures = 0;

`ifdef IF_RVC_EN
    localparam logic [31:0] C_RVC  = 32'd1;
    localparam logic [31:0] C_PNOP = 32'h46;
`else
    localparam logic [31:0] C_RVC  = 32'd0;
    localparam logic [31:0] C_PNOP = 32'h48;
`endif
    localparam logic [31:0] C_ADDI = 32'h0010_0093;

    ins_fetch_q dut (
        .clk(clk), .rst(rst), .en(en),
        .ic_en_i(ic_en_i), .ic_ins_i(ic_ins_i), .ic_en_o(ic_en_o), .ic_pc_o(ic_pc_o),
        .br_flag_i(br_flag_i), .br_abr_i(br_abr_i), .br_tpc_i(br_tpc_i), .br_cbt_i(br_cbt_i),
        .bp_pc_o(bp_pc_o), .bp_br_i(bp_br_i), .bp_en_o(bp_en_o), .bp_abr_o(bp_abr_o),
        .bp_tpc_o(bp_tpc_o), .is_en_o(is_en_o), .is_ic_o(is_ic_o), .is_ins_o(is_ins_o),
        .is_pc_o(is_pc_o), .is_pbr_o(is_pbr_o), .full_i(full_i), .fq_cnt_o(fq_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ic_en_i = 1'b0; ic_ins_i = '0; br_flag_i = 1'b0;
        br_abr_i = 1'b0; br_tpc_i = '0; br_cbt_i = '0; bp_br_i = 1'b0; full_i = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_pc", ic_pc_o, 32'h0);
        chk("rst_cnt", 32'(fq_cnt_o), 32'd0);
        chk("rst_is_en", 32'(is_en_o), 32'd0);
        chk("rst_ic_en", 32'(ic_en_o), 32'd0);
        chk("rst_is_ins", is_ins_o, 32'h0);
        chk("rst_is_pc", is_pc_o, 32'h0);
        chk("rst_is_ic", 32'(is_ic_o), 32'd0);
        chk("rst_is_pbr", 32'(is_pbr_o), 32'd0);

        // addi at 0x0, then jal +16 at 0x4
        ic_en_i = 1'b1; ic_ins_i = C_ADDI;
        step();
        chk("addi_pc", ic_pc_o, 32'h4);
        chk("addi_cnt", 32'(fq_cnt_o), 32'd1);
        chk("addi_no_issue", 32'(is_en_o), 32'd0);
        ic_ins_i = 32'h0100_006F;
        step();
        chk("jal_pc", ic_pc_o, 32'h14);
        chk("iss0_en", 32'(is_en_o), 32'd1);
        chk("iss0_pc", is_pc_o, 32'h0);
        chk("iss0_ins", is_ins_o, C_ADDI);
        chk("iss0_cnt", 32'(fq_cnt_o), 32'd1);

        // three miss cycles
        ic_en_i = 1'b0;
        step();
        chk("iss1_en", 32'(is_en_o), 32'd1);
        chk("iss1_pc", is_pc_o, 32'h4);
        chk("iss1_cnt", 32'(fq_cnt_o), 32'd0);
        chk("miss0_ic_en", 32'(ic_en_o), 32'd1);
        chk("miss0_pc", ic_pc_o, 32'h14);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("miss_ic_en", 32'(ic_en_o), 32'd1);
            chk("miss_is_en", 32'(is_en_o), 32'd0);
            chk("miss_pc", ic_pc_o, 32'h14);
            chk("miss_is_pc_hold", is_pc_o, 32'h4);
        end

        // redirect to 0x20; feedback is combinational
        br_flag_i = 1'b1; br_cbt_i = 32'h20; br_abr_i = 1'b1; br_tpc_i = 32'h77;
        #1;
        chk("bp_en", 32'(bp_en_o), 32'd1);
        chk("bp_abr", 32'(bp_abr_o), 32'd1);
        chk("bp_tpc", bp_tpc_o, 32'h77);
        chk("bp_pc", bp_pc_o, 32'h14);
        step();
        br_flag_i = 1'b0; br_abr_i = 1'b0;
        chk("redir_pc", ic_pc_o, 32'h20);
        chk("redir_ic_en", 32'(ic_en_o), 32'd0);

        // beq +8 predicted taken
        ic_en_i = 1'b1; ic_ins_i = 32'h0000_0463; bp_br_i = 1'b1;
        step();
        chk("beq_t_pc", ic_pc_o, 32'h28);
        ic_en_i = 1'b0; bp_br_i = 1'b0;
        step();
        chk("beq_t_is_en", 32'(is_en_o), 32'd1);
        chk("beq_t_is_pc", is_pc_o, 32'h20);
        chk("beq_t_pbr", 32'(is_pbr_o), 32'd1);
        chk("beq_t_is_ic", 32'(is_ic_o), 32'd0);

        // same beq predicted not taken
        br_flag_i = 1'b1; br_cbt_i = 32'h20;
        step();
        br_flag_i = 1'b0;
        ic_en_i = 1'b1;
        step();
        chk("beq_n_pc", ic_pc_o, 32'h24);
        ic_en_i = 1'b0;
        step();
        chk("beq_n_is_en", 32'(is_en_o), 32'd1);
        chk("beq_n_pbr", 32'(is_pbr_o), 32'd0);

        // fill the queue under back-pressure
        full_i = 1'b1; ic_en_i = 1'b1; ic_ins_i = C_ADDI;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fill_cnt", 32'(fq_cnt_o), 32'(i + 1));
            chk("fill_pc", ic_pc_o, 32'h28 + 32'(4 * i));
            chk("fill_is_en", 32'(is_en_o), 32'd0);
        end
        step();
        chk("full_cnt", 32'(fq_cnt_o), 32'd4);
        chk("full_pc", ic_pc_o, 32'h34);
        ic_en_i = 1'b0;
        step();
        chk("full_ic_en", 32'(ic_en_o), 32'd0);

        full_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_is_en", 32'(is_en_o), 32'd1);
            chk("drain_is_pc", is_pc_o, 32'h24 + 32'(4 * i));
            chk("drain_cnt", 32'(fq_cnt_o), 32'(3 - i));
        end

        // flush with three entries queued
        full_i = 1'b1; ic_en_i = 1'b1;
        step(); step(); step();
        chk("pre_flush_cnt", 32'(fq_cnt_o), 32'd3);
        chk("pre_flush_pc", ic_pc_o, 32'h40);
        br_flag_i = 1'b1; br_cbt_i = 32'h100; br_tpc_i = 32'h40; full_i = 1'b0;
        #1;
        chk("fl_bp_en", 32'(bp_en_o), 32'd1);
        chk("fl_bp_tpc", bp_tpc_o, 32'h40);
        chk("fl_bp_abr", 32'(bp_abr_o), 32'd0);
        step();
        br_flag_i = 1'b0; ic_en_i = 1'b0;
        chk("fl_cnt", 32'(fq_cnt_o), 32'd0);
        chk("fl_is_en", 32'(is_en_o), 32'd0);
        chk("fl_pc", ic_pc_o, 32'h100);
        step();
        chk("fl_is_en2", 32'(is_en_o), 32'd0);
        chk("fl_ic_en2", 32'(ic_en_o), 32'd1);

        // c.j +4 at 0x40, c.nop at 0x44
        br_flag_i = 1'b1; br_cbt_i = 32'h40;
        step();
        br_flag_i = 1'b0;
        ic_en_i = 1'b1; ic_ins_i = 32'h0000_A011;
        step();
        chk("cj_pc", ic_pc_o, 32'h44);
        ic_ins_i = 32'h0000_0001;
        step();
        chk("cj_is_ic", 32'(is_ic_o), C_RVC);
        chk("cj_is_pc", is_pc_o, 32'h40);
        chk("cj_is_ins", is_ins_o, 32'h0000_A011);
        chk("cnop_pc", ic_pc_o, C_PNOP);
        ic_en_i = 1'b0;
        step();
        chk("cnop_is_ic", 32'(is_ic_o), C_RVC);
        chk("cnop_is_pc", is_pc_o, 32'h44);

        // en low mid-stream
        ic_en_i = 1'b1; ic_ins_i = C_ADDI;
        step();
        chk("en_pre_cnt", 32'(fq_cnt_o), 32'd1);
        step();
        chk("en_pre_is_en", 32'(is_en_o), 32'd1);
        chk("en_pre_pc", ic_pc_o, C_PNOP + 32'h8);
        en = 1'b0;
        step();
        chk("en_lo_is_en", 32'(is_en_o), 32'd0);
        chk("en_lo_cnt", 32'(fq_cnt_o), 32'd1);
        chk("en_lo_pc", ic_pc_o, C_PNOP + 32'h8);
        ic_en_i = 1'b0;
        step();
        chk("en_lo_ic_en", 32'(ic_en_o), 32'd0);
        chk("en_lo_pc2", ic_pc_o, C_PNOP + 32'h8);
        chk("en_lo_is_pc", is_pc_o, C_PNOP);
        en = 1'b1;
        step();
        chk("en_hi_is_en", 32'(is_en_o), 32'd1);
        chk("en_hi_is_pc", is_pc_o, C_PNOP + 32'h4);
        chk("en_hi_cnt", 32'(fq_cnt_o), 32'd0);
        chk("en_hi_ic_en", 32'(ic_en_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ins_fetch_q.md
# ins_fetch_q

Parametrised instruction fetcher with a decoupling instruction queue between the instruction cache and the decoder. It holds the PC, requests instructions from the combinational instruction cache, and applies static next-PC rules (direct JAL, predicted conditional branches). Fetched entries are buffered in a `FQ_DEPTH`-entry FIFO so fetching continues while ROB/RS/LSB back-pressure stalls issue. It sits between ins_cache/predictor and decoder, and is flushed by ROB branch resolution.

## Interface

- `DAT_W`, 32, instruction/PC width
- `FQ_DEPTH`, 4, queue entries; must be a power of two, at least 2
- `FQ_AW`, 2, log2(`FQ_DEPTH`)
- `RST_PC`, 0, PC after reset
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  global enable; low freezes all state
- `ic_en_i`  in  1  instruction at `ic_pc_o` valid this cycle (cache hit)
- `ic_ins_i`  in  DAT_W  instruction word at `ic_pc_o`
- `ic_en_o`  out  1  miss request for `ic_pc_o`
- `ic_pc_o`  out  DAT_W  current fetch PC
- `br_flag_i`  in  1  ROB mispredict/redirect
- `br_abr_i`  in  1  branch actually taken
- `br_tpc_i`  in  DAT_W  PC of the resolved branch
- `br_cbt_i`  in  DAT_W  redirect target
- `bp_pc_o`  out  DAT_W  lookup PC (= `ic_pc_o`)
- `bp_br_i`  in  1  predicted taken for `bp_pc_o` (combinational)
- `bp_en_o`, `bp_abr_o`, `bp_tpc_o`  out  1/1/DAT_W  feedback; wired straight from `br_flag_i`, `br_abr_i`, `br_tpc_i`
- `is_en_o`  out  1  issue valid, one-cycle pulse
- `is_ic_o`  out  1  0 = 32-bit, 1 = compressed
- `is_ins_o`  out  DAT_W  issued instruction
- `is_pc_o`  out  DAT_W  issued PC
- `is_pbr_o`  out  1  predicted-taken flag of the issued instruction
- `full_i`  in  1  downstream full; blocks issue
- `fq_cnt_o`  out  FQ_AW+1  queue occupancy

## Operation

- Reset values:
  - `pc` = `RST_PC`.
  - Queue empty: head, tail and count = 0.
  - `ic_en_o`, `is_en_o`, `is_ic_o`, `is_pbr_o` = 0.
  - `is_ins_o`, `is_pc_o` = 0.
- Priority order: `rst` > `en` low (hold all state; `is_en_o` forced 0, `ic_en_o` forced 0) > `br_flag_i` > normal operation.
- Redirect (`en` and `br_flag_i` both high):
  - `pc` <= `br_cbt_i`.
  - Queue cleared.
  - `is_en_o`, `ic_en_o` <= 0.
  - Same-cycle enqueue and issue are discarded.
- Enqueue is allowed when `ic_en_i` is high and the start-of-cycle count < `FQ_DEPTH`.
  - Writes {pc, ins, ic, `bp_br_i`} at the tail.
  - `pc` advances per the next-PC rules.
- `ic_en_o` <= 1 when `ic_en_i` is low and count < `FQ_DEPTH`; otherwise 0.
- Issue is allowed when the start-of-cycle count > 0 and `full_i` is low.
  - Head entry is registered onto `is_*`, `is_en_o` <= 1, head advances.
  - Otherwise `is_en_o` <= 0; `is_ins_o`, `is_pc_o`, `is_ic_o`, `is_pbr_o` hold their values.
- Simultaneous enqueue and issue leaves the count unchanged. A full queue accepts nothing even if it issues in the same cycle (no same-cycle bypass). Pointers wrap modulo `FQ_DEPTH`.
- Next-PC rules for 32-bit instructions (`ins[1:0]` = 11). All arithmetic is modulo 2^DAT_W with sign-extended immediates.
  - opcode 1101111 (JAL): pc + {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
  - opcode 1100011 (branch) with `bp_br_i` high: pc + {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - Otherwise, including JALR: pc + 4.
- Next-PC rules for compressed instructions, keyed on {ins[15:13], ins[1:0]}:
  - 00101 (c.jal) and 10101 (c.j): pc + {ins[12], ins[8], ins[10:9], ins[6], ins[7], ins[2], ins[11], ins[5:3], 0}.
  - 11001 (c.beqz) and 11101 (c.bnez) with `bp_br_i` high: pc + {ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 0}.
  - Otherwise: pc + 2.
- `fq_cnt_o` is the registered count.

## Timing

- Cache hit at edge N: entry enqueued at N, earliest `is_en_o` high after edge N+1. Minimum latency is 2 cycles.
- Sustained throughput is one instruction per cycle on consecutive hits with `full_i` low; the queue stays at 0–1 entries.
- `ic_en_o` is a registered one-cycle pulse, re-asserted every cycle while the miss persists.
- A redirect takes effect on the next edge: `ic_pc_o` = `br_cbt_i` one cycle after `br_flag_i`. No stale `is_en_o` is asserted after the redirect edge.
- `bp_*` feedback outputs are combinational pass-through (zero latency).

## Configuration

- `IF_RVC_EN` defined:
  - Compressed support enabled.
  - `ins[1:0]` != 11 marks an instruction compressed; `is_ic_o` = 1.
  - Compressed next-PC rules apply.
- `IF_RVC_EN` undefined:
  - Every instruction is treated as 32-bit.
  - `is_ic_o` is constant 0.
  - Only the 32-bit next-PC rules apply (non-JAL, non-branch: pc + 4).

## Test plan

- Reset, then hits at 0x0 `addi` (0x00100093) and 0x4 `jal +16` (0x0100006F) -> issues PC 0x0 then 0x4; next `ic_pc_o` = 0x14.
- `beq` (0x00000463) at 0x20 with `bp_br_i` = 1 -> next PC 0x28 and `is_pbr_o` = 1; same with `bp_br_i` = 0 -> next PC 0x24 and `is_pbr_o` = 0.
- Hold `full_i` = 1 with continuous hits -> queue fills to `FQ_DEPTH`, then enqueue stops and `ic_en_o` stays 0. Release -> `FQ_DEPTH` in-order issues on consecutive cycles with PCs matching the fetch order.
- With 3 entries queued, assert `br_flag_i` with `br_cbt_i` = 0x100 -> `fq_cnt_o` = 0, no `is_en_o`, `ic_pc_o` = 0x100 next cycle. `bp_en_o`/`bp_tpc_o` mirror the inputs in the same cycle.
- With `IF_RVC_EN`: `c.j` (0xA011, offset +4) at 0x40 -> `is_ic_o` = 1, next PC 0x44. Then `c.nop` (0x0001) at 0x44 -> next PC 0x46.
- `ic_en_i` = 0 for 3 cycles -> `ic_en_o` = 1 each cycle and `pc` holds. `en` low mid-stream -> all state frozen, `is_en_o` = 0.
